// File: rtl/if_stage_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package if_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam logic [WORD_DATA_W-1:0] NOP_INSN_DEFAULT = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Single-outstanding instruction bus between the fetch stage and its memory slave.
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rdy;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (output bus_req, bus_addr, input bus_rdy, bus_rd_data);
  modport slave  (input bus_req, bus_addr, output bus_rdy, bus_rd_data);
endinterface

// File: rtl/if_stage_reg.sv
// IF/ID pipeline register: rst > flush (bubble) > stall (hold) > load > bubble.
module if_reg
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = WORD_ADDR_W,
  parameter int                DATA_W   = WORD_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_insn,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc   <= '0;
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else if (flush) begin
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        if_pc   <= load_pc;
        if_insn <= load_insn;
        if_en   <= 1'b1;
      end else begin
        if_insn <= NOP_INSN;
        if_en   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding bus master FSM, hold buffer
// and the IF/ID register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W    = WORD_ADDR_W,
  parameter int                DATA_W    = WORD_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [DATA_W-1:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  if_stage_if.master        bus,
  output logic              if_busy,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  if_state_e         state, state_next;
  logic [ADDR_W-1:0] fetch_pc, drain_addr, target;
  logic [DATA_W-1:0] hold_buf, load_insn;
  logic              redirect, load;

  // A branch seen under stall is ignored; decode presents it again later.
  assign redirect = flush | (br_taken & ~stall);
  assign target   = flush ? new_pc : br_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    unique case (state)
      FETCH: begin
        if (redirect)                   state_next = bus.bus_rdy ? FETCH : DRAIN;
        else if (bus.bus_rdy && stall)  state_next = HOLD;
      end
      DRAIN: if (bus.bus_rdy)           state_next = FETCH;
      HOLD:  if (redirect || !stall)    state_next = FETCH;
      default:                          state_next = FETCH;
    endcase
  end

  always_comb begin
    bus.bus_req  = 1'b1;
    bus.bus_addr = fetch_pc;
    load         = 1'b0;
    load_insn    = bus.bus_rd_data;
    unique case (state)
      FETCH: load = bus.bus_rdy && !stall && !redirect;
      DRAIN: bus.bus_addr = drain_addr;
      HOLD: begin
        bus.bus_req = 1'b0;
        load        = !stall && !redirect;
        load_insn   = hold_buf;
      end
      default: ;
    endcase
  end

  assign if_busy = bus.bus_req & ~bus.bus_rdy;

  // Every IF/ID load consumes the instruction at fetch_pc, so it also advances it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_VEC;
      drain_addr <= RESET_VEC;
    end else begin
      if (redirect)  fetch_pc <= target;
      else if (load) fetch_pc <= fetch_pc + ADDR_W'(1);
      if (state == FETCH && redirect && !bus.bus_rdy) drain_addr <= fetch_pc;
    end
  end

  // NOTE: hold_buf has no reset; it is only read in HOLD, which is entered by writing it.
  always_ff @(posedge clk) begin
    if (state == FETCH && bus.bus_rdy && stall && !flush) hold_buf <= bus.bus_rd_data;
  end

  if_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INSN (NOP_INSN)
  ) u_if_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .load      (load),
    .load_pc   (fetch_pc),
    .load_insn (load_insn),
    .if_pc     (if_pc),
    .if_insn   (if_insn),
    .if_en     (if_en)
  );

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage against a transaction-level fetch model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int             AW  = WORD_ADDR_W;
  localparam int             DW  = WORD_DATA_W;
  localparam logic [AW-1:0]  RV  = 30'h10;
  localparam logic [DW-1:0]  NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, stall, flush, br_taken;
  logic [AW-1:0] new_pc, br_addr;
  logic          if_busy, if_en;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;

  if_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [DW-1:0] insn_of(logic [AW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.bus_rd_data = insn_of(bus.bus_addr);

  if_stage #(.ADDR_W(AW), .DATA_W(DW), .RESET_VEC(RV), .NOP_INSN(NOP)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .bus      (bus),
    .if_busy  (if_busy),
    .if_pc    (if_pc),
    .if_insn  (if_insn),
    .if_en    (if_en)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit          chk;
    logic [31:0] bus_view;   // {bus_req, if_busy, bus_addr}
    logic [62:0] ifid_view;  // {if_en, if_pc, if_insn}
  } exp_t;

  exp_t q[$];

  // Model: next PC to deliver, an abandoned in-flight request, a fetched-but-unaccepted word.
  logic [AW-1:0] m_pc, m_stale_addr, m_ifpc;
  logic [DW-1:0] m_buf_data, m_insn;
  bit            m_stale, m_buf, m_en;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        check("bus", 64'({bus.bus_req, if_busy, bus.bus_addr}), 64'(e.bus_view));
        check("ifid", 64'({if_en, if_pc, if_insn}), 64'(e.ifid_view));
      end
    end
  end

  task automatic step(bit r, bit s, bit f, logic [AW-1:0] np, bit bt, logic [AW-1:0] ba,
                      bit rdy_in, bit chk);
    exp_t          e;
    logic [AW-1:0] addr, tgt;
    logic [DW-1:0] data;
    bit            req, rdy, redirect;
    @(posedge clk);
    #2;
    req  = !m_buf;
    rdy  = rdy_in && req && !r;
    addr = m_stale ? m_stale_addr : m_pc;
    rst = r; stall = s; flush = f; new_pc = np; br_taken = bt; br_addr = ba;
    bus.bus_rdy = rdy;
    e.chk       = chk;
    e.bus_view  = {req, req && !rdy, addr};
    e.ifid_view = {m_en, m_ifpc, m_insn};
    q.push_back(e);
    data = insn_of(addr);
    if (r) begin
      m_pc = RV; m_stale = 0; m_buf = 0; m_en = 0; m_ifpc = '0; m_insn = NOP;
      return;
    end
    redirect = f || (bt && !s);
    tgt      = f ? np : ba;
    if (f) begin
      m_en = 0; m_insn = NOP;
    end else if (!s) begin
      if (!bt && m_buf) begin
        m_en = 1; m_ifpc = m_pc; m_insn = m_buf_data;
      end else if (!bt && !m_stale && rdy) begin
        m_en = 1; m_ifpc = m_pc; m_insn = data;
      end else begin
        m_en = 0; m_insn = NOP;
      end
    end
    if (redirect) begin
      if (req && !rdy && !m_stale) begin
        m_stale = 1; m_stale_addr = m_pc;
      end else if (m_stale && rdy) begin
        m_stale = 0;
      end
      m_buf = 0;
      m_pc  = tgt;
    end else if (m_stale) begin
      if (rdy) m_stale = 0;
    end else if (m_buf) begin
      if (!s) begin m_buf = 0; m_pc = m_pc + 1'b1; end
    end else if (rdy) begin
      if (s) begin m_buf = 1; m_buf_data = data; end
      else m_pc = m_pc + 1'b1;
    end
  endtask

  // Plain cycle: no reset, no redirect.
  task automatic run(bit s, bit rdy);
    step(0, s, 0, '0, 0, '0, rdy, 1);
  endtask

  task automatic go_to(logic [AW-1:0] pc);
    step(0, 0, 1, pc, 0, '0, 1, 1);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; br_taken = 0; new_pc = '0; br_addr = '0;
    bus.bus_rdy = 0;
    m_pc = RV; m_stale = 0; m_buf = 0; m_en = 0; m_ifpc = '0; m_insn = NOP;

    step(1, 0, 0, '0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, '0, 0, 1);
    repeat (4) run(0, 1);                      // zero-wait stream from RESET_VEC

    go_to(30'h20);                             // two wait states at 0x20
    run(0, 0); run(0, 0); run(0, 1); run(0, 1);

    go_to(30'h30);                             // stall across a completed fetch
    run(1, 1); run(1, 0); run(1, 0); run(0, 0); run(0, 1);

    go_to(30'h40);                             // branch while 0x40 is outstanding
    step(0, 0, 0, '0, 1, 30'h100, 0, 1);
    run(0, 0); run(0, 1); run(0, 1); run(0, 1);

    step(0, 1, 1, 30'h200, 1, 30'h300, 1, 1); // flush beats branch under stall
    run(0, 1); run(0, 1);

    go_to(30'h3FFF_FFFF);                      // PC wrap
    repeat (3) run(0, 1);

    step(0, 0, 0, '0, 1, 30'h55, 0, 1);       // into DRAIN, then reset there
    step(1, 0, 0, '0, 0, '0, 0, 1);
    run(0, 0); run(0, 1); run(0, 1);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(11) == 0,
           AW'($urandom), $urandom_range(7) == 0, AW'($urandom),
           $urandom_range(2) != 0, 1);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
